// File: rtl/imem_pkg.sv
// Shared constants and helpers for the row/column instruction memory.
package imem_pkg;

  localparam int unsigned MaxDataWidth = 256;
  localparam int unsigned MaxBeWidth   = MaxDataWidth / 8;
  localparam int unsigned MaxAddrBits  = 32;

  localparam logic [31:0] NopWordDefault = 32'h0000_0013;

  // Callers zero-extend into the wide types and truncate the result back.
  function automatic logic [MaxDataWidth-1:0] byte_merge(
    input logic [MaxDataWidth-1:0] old_word,
    input logic [MaxDataWidth-1:0] new_word,
    input logic [MaxBeWidth-1:0]   be
  );
    logic [MaxDataWidth-1:0] res;
    res = old_word;
    for (int i = 0; i < int'(MaxBeWidth); i++) begin
      if (be[i]) res[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return res;
  endfunction

  function automatic logic [MaxAddrBits-1:0] row_of(input logic [MaxAddrBits-1:0] addr,
                                                    input int unsigned col_bits);
    return addr >> col_bits;
  endfunction

  function automatic logic [MaxAddrBits-1:0] col_of(input logic [MaxAddrBits-1:0] addr,
                                                    input int unsigned col_bits);
    logic [MaxAddrBits-1:0] mask;
    mask = '1;
    mask = ~(mask << col_bits);
    return addr & mask;
  endfunction

endpackage

// File: rtl/imem_rsp_reg.sv
// Response holding register: one-deep valid/ready stage that freezes its payload while stalled.
module imem_rsp_reg #(
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 uninit_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_data_o,
  output logic                 rsp_uninit_o
);

  logic                 valid_q, valid_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic                 uninit_q, uninit_d;
  logic                 accept;

  assign req_ready_o = !rst_i && (!valid_q || rsp_ready_i);
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    uninit_d = uninit_q;
    if (accept) begin
      valid_d  = 1'b1;
      data_d   = data_i;
      uninit_d = uninit_i;
    end else if (rsp_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      uninit_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      uninit_q <= uninit_d;
    end
  end

  assign rsp_valid_o  = valid_q;
  assign rsp_data_o   = data_q;
  assign rsp_uninit_o = uninit_q;

endmodule

// File: rtl/xdecode.sv
// Binary to one-hot address decoder.
module xdecode #(
  parameter int unsigned Width = 4
) (
  input  logic [Width-1:0]      addr_i,
  output logic [(1<<Width)-1:0] onehot_o
);

  always_comb begin
    onehot_o         = '0;
    onehot_o[addr_i] = 1'b1;
  end

endmodule

// File: rtl/instr_mem_fetch.sv
// Row/column instruction memory with a valid/ready fetch port, byte-enabled writes,
// write-first forwarding and per-word initialised tracking.
module instr_mem_fetch
  import imem_pkg::*;
#(
  parameter int unsigned           ROW_BITS   = 4,
  parameter int unsigned           COL_BITS   = 4,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(NopWordDefault)
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ROW_BITS+COL_BITS-1:0] req_addr,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_WIDTH-1:0]        rsp_data,
  output logic                         rsp_uninit,
  input  logic                         WriteEnable,
  input  logic [DATA_WIDTH/8-1:0]      wr_byte_en,
  input  logic [ROW_BITS+COL_BITS-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data
);

  localparam int unsigned AddrBits = ROW_BITS + COL_BITS;
  localparam int unsigned Rows     = 1 << ROW_BITS;
  localparam int unsigned Cols     = 1 << COL_BITS;
  localparam int unsigned Words    = 1 << AddrBits;

  logic [DATA_WIDTH-1:0] mem_q [Rows][Cols];
  logic [Words-1:0]      init_q;

  logic [ROW_BITS-1:0]   wr_row, rd_row;
  logic [COL_BITS-1:0]   wr_col, rd_col;
  logic [Rows-1:0]       wr_row_oh;
  logic [Cols-1:0]       wr_col_oh;
  logic                  wr_en, fwd;
  logic [DATA_WIDTH-1:0] wr_old, wr_word, fetch_data;
  logic                  fetch_uninit;

  assign wr_row = ROW_BITS'(row_of(MaxAddrBits'(wr_addr), COL_BITS));
  assign wr_col = COL_BITS'(col_of(MaxAddrBits'(wr_addr), COL_BITS));
  assign rd_row = ROW_BITS'(row_of(MaxAddrBits'(req_addr), COL_BITS));
  assign rd_col = COL_BITS'(col_of(MaxAddrBits'(req_addr), COL_BITS));

  xdecode #(.Width(ROW_BITS)) u_row_dec (
    .addr_i   (wr_row),
    .onehot_o (wr_row_oh)
  );

  xdecode #(.Width(COL_BITS)) u_col_dec (
    .addr_i   (wr_col),
    .onehot_o (wr_col_oh)
  );

  assign wr_en = WriteEnable && !Reset;

  // Lanes not enabled on a word's first write become zero rather than stale storage.
  always_comb begin
    wr_old  = init_q[wr_addr] ? mem_q[wr_row][wr_col] : '0;
    wr_word = DATA_WIDTH'(byte_merge(MaxDataWidth'(wr_old), MaxDataWidth'(wr_data),
                                     MaxBeWidth'(wr_byte_en)));
  end

  always_comb begin
    fwd          = wr_en && (wr_addr == req_addr);
    fetch_uninit = !fwd && !init_q[req_addr];
    if (fwd) begin
      fetch_data = wr_word;
    end else if (init_q[req_addr]) begin
      fetch_data = mem_q[rd_row][rd_col];
    end else begin
      fetch_data = NOP_WORD;
    end
  end

  always_ff @(posedge Clock) begin
    for (int unsigned r = 0; r < Rows; r++) begin
      for (int unsigned c = 0; c < Cols; c++) begin
        if (wr_en && wr_row_oh[r] && wr_col_oh[c]) mem_q[r][c] <= wr_word;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      init_q <= '0;
    end else if (wr_en) begin
      init_q[wr_addr] <= 1'b1;
    end
  end

  imem_rsp_reg #(.DataWidth(DATA_WIDTH)) u_rsp (
    .clk_i        (Clock),
    .rst_i        (Reset),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .data_i       (fetch_data),
    .uninit_i     (fetch_uninit),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_data_o   (rsp_data),
    .rsp_uninit_o (rsp_uninit)
  );

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed bench for instr_mem_fetch with a word-level reference model and per-cycle compare.
module tb_instr_mem_fetch;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_addr = 8'h00;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_uninit;
  logic        WriteEnable = 1'b0;
  logic [3:0]  wr_byte_en = 4'h0;
  logic [7:0]  wr_addr = 8'h00;
  logic [31:0] wr_data = 32'h0;

  int checks   = 0;
  int failures = 0;

  instr_mem_fetch dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_uninit  (rsp_uninit),
    .WriteEnable (WriteEnable),
    .wr_byte_en  (wr_byte_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: word array plus written flags, and the expected response slot.
  bit [31:0] m_mem [256];
  bit        m_init [256];
  bit        m_live = 1'b0;
  bit        e_valid = 1'b0;
  bit [31:0] e_data = 32'h0;
  bit        e_uninit = 1'b0;

  always @(posedge Clock) begin
    bit        accept;
    bit [31:0] nw;
    if (Reset) begin
      m_live   = 1'b1;
      e_valid  = 1'b0;
      e_data   = 32'h0;
      e_uninit = 1'b0;
      for (int i = 0; i < 256; i++) m_init[i] = 1'b0;
    end else begin
      accept = req_valid && (!e_valid || rsp_ready);
      if (WriteEnable) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_byte_en[b]) nw[b*8 +: 8] = wr_data[b*8 +: 8];
          else if (m_init[wr_addr]) nw[b*8 +: 8] = m_mem[wr_addr][b*8 +: 8];
          else nw[b*8 +: 8] = 8'h00;
        end
        m_mem[wr_addr]  = nw;
        m_init[wr_addr] = 1'b1;
      end
      if (accept) begin
        e_valid  = 1'b1;
        e_uninit = !m_init[req_addr];
        e_data   = m_init[req_addr] ? m_mem[req_addr] : 32'h0000_0013;
      end else if (rsp_ready) begin
        e_valid = 1'b0;
      end
    end
  end

  always @(negedge Clock) begin
    if (m_live) begin
      chk("model_rsp_valid", 32'(rsp_valid), 32'(e_valid));
      chk("model_rsp_data", rsp_data, e_data);
      chk("model_rsp_uninit", 32'(rsp_uninit), 32'(e_uninit));
      chk("model_req_ready", 32'(req_ready), 32'(!Reset && (!e_valid || rsp_ready)));
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    int seen;
    step();
    step();
    Reset = 1'b0;

    // Fetch of a never-written word returns NOP.
    req_valid = 1'b1; req_addr = 8'h00; rsp_ready = 1'b1;
    step();
    chk("nop_valid", 32'(rsp_valid), 32'd1);
    chk("nop_data", rsp_data, 32'h0000_0013);
    chk("nop_uninit", 32'(rsp_uninit), 32'd1);
    req_valid = 1'b0;
    step();
    chk("drain_valid", 32'(rsp_valid), 32'd0);

    // Full write then fetch.
    WriteEnable = 1'b1; wr_byte_en = 4'hF; wr_addr = 8'h35; wr_data = 32'hDEAD_BEEF;
    step();
    WriteEnable = 1'b0;
    req_valid = 1'b1; req_addr = 8'h35;
    step();
    chk("wr_rd_data", rsp_data, 32'hDEAD_BEEF);
    chk("wr_rd_uninit", 32'(rsp_uninit), 32'd0);
    req_valid = 1'b0;
    step();

    // Same-edge partial write and fetch of an uninitialised word.
    WriteEnable = 1'b1; wr_byte_en = 4'b0101; wr_addr = 8'h7A; wr_data = 32'h1122_3344;
    req_valid = 1'b1; req_addr = 8'h7A;
    step();
    chk("rdw_data", rsp_data, 32'h0022_0044);
    chk("rdw_uninit", 32'(rsp_uninit), 32'd0);
    WriteEnable = 1'b0; req_valid = 1'b0;
    step();

    // Stall with writes to the held address.
    req_valid = 1'b1; req_addr = 8'h35; rsp_ready = 1'b0;
    step();
    req_addr = 8'h00;
    WriteEnable = 1'b1; wr_byte_en = 4'hF; wr_addr = 8'h35; wr_data = 32'h0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_ready", 32'(req_ready), 32'd0);
      chk("stall_data", rsp_data, 32'hDEAD_BEEF);
      step();
    end
    chk("stall_hold_end", rsp_data, 32'hDEAD_BEEF);
    WriteEnable = 1'b0; rsp_ready = 1'b1; req_addr = 8'h35;
    step();
    chk("refetch_data", rsp_data, 32'h0);
    chk("refetch_uninit", 32'(rsp_uninit), 32'd0);

    // Byte-enable zero still marks the word written.
    req_valid = 1'b0;
    WriteEnable = 1'b1; wr_byte_en = 4'h0; wr_addr = 8'h10; wr_data = 32'hFFFF_FFFF;
    step();
    WriteEnable = 1'b0; req_valid = 1'b1; req_addr = 8'h10;
    step();
    chk("be0_data", rsp_data, 32'h0);
    chk("be0_uninit", 32'(rsp_uninit), 32'd0);

    // Full-rate stream over the whole address space.
    seen = 0;
    for (int i = 0; i < 256; i++) begin
      req_addr = 8'(i);
      step();
      if (rsp_valid) seen++;
      if (i == 8'h35) chk("stream_35", rsp_data, 32'h0);
      if (i == 8'h7A) chk("stream_7a", rsp_data, 32'h0022_0044);
      if (i == 8'h00) chk("stream_00", rsp_data, 32'h0000_0013);
    end
    chk("stream_count", 32'(seen), 32'd256);
    req_valid = 1'b0;
    step();

    // Reset while stalled drops the response and forgets written words.
    req_valid = 1'b1; req_addr = 8'h35; rsp_ready = 1'b0;
    step();
    chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
    Reset = 1'b1; req_valid = 1'b0;
    WriteEnable = 1'b1; wr_byte_en = 4'hF; wr_addr = 8'h20; wr_data = 32'hCAFE_F00D;
    step();
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_data", rsp_data, 32'h0);
    chk("rst_uninit", 32'(rsp_uninit), 32'd0);
    Reset = 1'b0; WriteEnable = 1'b0; rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 8'h35;
    step();
    chk("post_rst_data", rsp_data, 32'h0000_0013);
    chk("post_rst_uninit", 32'(rsp_uninit), 32'd1);
    req_addr = 8'h20;
    step();
    chk("rst_write_ignored", 32'(rsp_uninit), 32'd1);
    req_valid = 1'b0;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
